dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port word-aligned data memory (64 x 32-bit, combinational read, write on posedge clk).
Requester 0 is the core load/store unit; requester 1 is the debug/DMA port.
Grants one request at a time using round-robin, drives the memory's write enable, address and write data, and returns a registered response.
Byte-enabled stores are handled as read-modify-write, because the memory supports whole-word writes only.

---
 rtl/dmem_arbiter_if.sv | 39 +++
 rtl/dmem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundle of the requester handshake, response and memory-side signals used by
// dmem_arbiter.
//   req_valid/req_ready/req_we  : per-requester request handshake and direction
//   req_addr/req_wdata/req_be   : per-requester packed address, store data, byte enables
//   rsp_valid/rsp_ready/rsp_rdata : per-requester response handshake, shared data
//   mem_we/mem_a/mem_wd/mem_rd  : single-port word memory (combinational read)
// Modports: slave = arbiter view, master = requesters + memory view.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ-1:0]          req_we;
    logic [NREQ*AW-1:0]       req_addr;
    logic [NREQ*DW-1:0]       req_wdata;
    logic [NREQ*(DW/8)-1:0]   req_be;
    logic [NREQ-1:0]          rsp_valid;
    logic [NREQ-1:0]          rsp_ready;
    logic [DW-1:0]            rsp_rdata;
    logic                     mem_we;
    logic [AW-1:0]            mem_a;
    logic [DW-1:0]            mem_wd;
    logic [DW-1:0]            mem_rd;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, mem_we, mem_a, mem_wd
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Round-robin two-port arbiter/sequencer in front of a single-port word memory.
// One transaction at a time: IDLE (grant) -> ACCESS (memory cycle) -> RESP.
// Partial stores are done as read-modify-write inside the single ACCESS cycle,
// using the memory's combinational read data.
// Ports:
//   clk   : clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : dmem_arbiter_if.slave (requests, responses, memory side)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_arbiter_if.slave   bus
);
    localparam int NBE = DW / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              prio_r;
    logic              g_r;
    logic              we_r;
    logic [AW-1:0]     addr_r;
    logic [DW-1:0]     wdata_r;
    logic [NBE-1:0]    be_r;
    logic [DW-1:0]     rdata_r;

    logic              grant_s;
    logic              any_valid_s;
    logic              accept_s;
    logic              rsp_done_s;
    logic              sel_we_s;
    logic [AW-1:0]     sel_addr_s;
    logic [DW-1:0]     sel_wdata_s;
    logic [NBE-1:0]    sel_be_s;

    logic [NREQ-1:0]   req_ready_s;
    logic [NREQ-1:0]   rsp_valid_s;
    logic [DW-1:0]     rsp_rdata_s;
    logic              mem_we_s;
    logic [AW-1:0]     mem_a_s;
    logic [DW-1:0]     mem_wd_s;

    // Byte-lane merge: lanes with be set take the new data, others keep the old word.
    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0]  new_w,
                                                  input logic [DW-1:0]  old_w,
                                                  input logic [NBE-1:0] be);
        logic [DW-1:0] m;
        m = old_w;
        for (int k = 0; k < NBE; k++) begin
            if (be[k]) begin
                m[8*k +: 8] = new_w[8*k +: 8];
            end else begin
                m[8*k +: 8] = old_w[8*k +: 8];
            end
        end
        return m;
    endfunction

    // Arbitration: prio breaks ties, a single valid requester always wins.
    always_comb begin
        grant_s = 1'b0;
        if (bus.req_valid[0] && bus.req_valid[1]) begin
            grant_s = prio_r;
        end else if (bus.req_valid[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Request field selection for the granted requester.
    always_comb begin
        sel_we_s    = grant_s ? bus.req_we[1]           : bus.req_we[0];
        sel_addr_s  = grant_s ? bus.req_addr[AW +: AW]   : bus.req_addr[0 +: AW];
        sel_wdata_s = grant_s ? bus.req_wdata[DW +: DW]  : bus.req_wdata[0 +: DW];
        sel_be_s    = grant_s ? bus.req_be[NBE +: NBE]   : bus.req_be[0 +: NBE];
    end

    // rst_n gates acceptance so req_ready is 0 while reset is held.
    assign any_valid_s = |bus.req_valid;
    assign accept_s    = (state_r == ST_IDLE) && any_valid_s && rst_n;
    assign rsp_done_s  = (state_r == ST_RESP) && bus.rsp_ready[g_r];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Transaction registers: latched request, captured read word, round-robin priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r  <= 1'b0;
            g_r     <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= {AW{1'b0}};
            wdata_r <= {DW{1'b0}};
            be_r    <= {NBE{1'b0}};
            rdata_r <= {DW{1'b0}};
        end else begin
            if (accept_s) begin
                g_r     <= grant_s;
                we_r    <= sel_we_s;
                addr_r  <= sel_addr_s & {{(AW-2){1'b1}}, 2'b00};
                wdata_r <= sel_wdata_s;
                be_r    <= sel_be_s;
            end
            if (state_r == ST_ACCESS) begin
                rdata_r <= bus.mem_rd;
            end
            if (rsp_done_s) begin
                prio_r <= ~g_r;
            end
        end
    end

    // Output decode from state; ACCESS write data depends on the live memory read.
    always_comb begin
        req_ready_s = {NREQ{1'b0}};
        rsp_valid_s = {NREQ{1'b0}};
        rsp_rdata_s = {DW{1'b0}};
        mem_we_s    = 1'b0;
        mem_a_s     = {AW{1'b0}};
        mem_wd_s    = {DW{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    req_ready_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_s;
                end else begin
                    req_ready_s = {NREQ{1'b0}};
                end
            end
            ST_ACCESS: begin
                mem_a_s = addr_r;
                // An all-zero byte enable is a no-op store: no write, but still answered.
                if (we_r && (be_r != {NBE{1'b0}})) begin
                    mem_we_s = 1'b1;
                    mem_wd_s = merge_bytes(wdata_r, bus.mem_rd, be_r);
                end else begin
                    mem_we_s = 1'b0;
                    mem_wd_s = {DW{1'b0}};
                end
            end
            ST_RESP: begin
                rsp_valid_s = {{(NREQ-1){1'b0}}, 1'b1} << g_r;
                rsp_rdata_s = rdata_r;
            end
            default: begin
                rsp_valid_s = {NREQ{1'b0}};
            end
        endcase
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_s;
    assign bus.rsp_rdata = rsp_rdata_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_a     = mem_a_s;
    assign bus.mem_wd    = mem_wd_s;
endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a 64 x 32-bit behavioural memory.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   we_cnt;
    int   dual_cnt;
    int   we_base;
    logic [31:0] ram [0:63];
    logic [1:0]  exp_oh;
    logic [31:0] exp_rd;

    dmem_arbiter_if #(.NREQ(2), .AW(32), .DW(32)) bus ();

    dmem_arbiter #(.NREQ(2), .AW(32), .DW(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on posedge.
    assign bus.mem_rd = ram[bus.mem_a[7:2]];
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            ram[bus.mem_a[7:2]] <= bus.mem_wd;
            we_cnt <= we_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if ($countones(bus.req_ready) > 1) dual_cnt = dual_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        total = 0; bad = 0; we_cnt = 0; dual_cnt = 0;
        for (int i = 0; i < 64; i++) ram[i] = 32'h1000_0000 + i;
        ram[5] = 32'hDEAD_BEEF;
        ram[2] = 32'h1122_3344;
        ram[3] = 32'h3333_3333;
        rst_n = 1'b0;
        bus.req_valid = 2'b01;
        bus.req_we    = 2'b00;
        bus.req_addr  = 64'h0;
        bus.req_wdata = 64'h0;
        bus.req_be    = 8'h0;
        bus.rsp_ready = 2'b00;
        #1;
        // Reset state: everything 0 even with a request pending.
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_mem_we", 32'(bus.mem_we), 32'h0);
        check("rst_mem_a", bus.mem_a, 32'h0);
        check("rst_mem_wd", bus.mem_wd, 32'h0);
        tick(); tick();
        rst_n = 1'b1;

        // Load after reset: req0 load 0x14.
        bus.req_addr[0 +: 32] = 32'h0000_0014;
        #1;
        check("ld_ready_c0", 32'(bus.req_ready), 32'h1);
        check("ld_mem_a_c0", bus.mem_a, 32'h0);
        tick();
        bus.req_valid = 2'b00;
        #1;
        check("ld_mem_a_c1", bus.mem_a, 32'h14);
        check("ld_mem_we_c1", 32'(bus.mem_we), 32'h0);
        check("ld_ready_c1", 32'(bus.req_ready), 32'h0);
        tick();
        check("ld_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("ld_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        bus.rsp_ready = 2'b01;
        tick();
        check("ld_rsp_drop", 32'(bus.rsp_valid), 32'h0);

        // Byte-merge store from req1 to 0x0B.
        we_base = we_cnt;
        bus.req_valid = 2'b10;
        bus.req_we    = 2'b10;
        bus.req_addr[32 +: 32]  = 32'h0000_000B;
        bus.req_wdata[32 +: 32] = 32'hAABB_CCDD;
        bus.req_be[4 +: 4]      = 4'b0101;
        bus.rsp_ready = 2'b10;
        #1;
        check("st_ready", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = 2'b00;
        #1;
        check("st_mem_we", 32'(bus.mem_we), 32'h1);
        check("st_mem_a", bus.mem_a, 32'h8);
        check("st_mem_wd", bus.mem_wd, 32'h11BB_33DD);
        tick();
        check("st_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        check("st_rsp_rdata", bus.rsp_rdata, 32'h1122_3344);
        check("st_resp_we", 32'(bus.mem_we), 32'h0);
        check("st_ram2", ram[2], 32'h11BB_33DD);
        tick();
        check("st_we_pulses", 32'(we_cnt - we_base), 32'h1);

        // Contention: both loading continuously, responses always accepted.
        bus.req_we    = 2'b00;
        bus.req_addr  = {32'h0000_0004, 32'h0000_0000};
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_oh = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_rd = (i % 2 == 0) ? 32'h1000_0000 : 32'h1000_0001;
            check("rr_grant", 32'(bus.req_ready), 32'(exp_oh));
            tick();
            check("rr_ready_access", 32'(bus.req_ready), 32'h0);
            tick();
            check("rr_rsp_valid", 32'(bus.rsp_valid), 32'(exp_oh));
            check("rr_rsp_rdata", bus.rsp_rdata, exp_rd);
            tick();
        end
        bus.req_valid = 2'b00;

        // Backpressure: req0 load of 0x14 held in RESP, req1 waiting.
        bus.req_addr  = {32'h0000_0004, 32'h0000_0014};
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b00;
        #1;
        check("bp_grant0", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 2'b10;
        bus.rsp_ready = 2'b10;  // non-granted rsp_ready must be ignored
        #1;
        check("bp_ready_access", 32'(bus.req_ready), 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
            check("bp_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
            check("bp_ready_hold", 32'(bus.req_ready), 32'h0);
            tick();
        end
        bus.rsp_ready = 2'b01;
        #1;
        check("bp_rsp_last", 32'(bus.rsp_valid), 32'h1);
        tick();
        check("bp_grant1", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b10;
        tick();
        check("bp_rsp1_valid", 32'(bus.rsp_valid), 32'h2);
        check("bp_rsp1_rdata", bus.rsp_rdata, 32'h1000_0001);
        tick();

        // be==0 store: no write, old word returned.
        we_base = we_cnt;
        bus.req_we    = 2'b01;
        bus.req_addr[0 +: 32]  = 32'h0000_0020;
        bus.req_wdata[0 +: 32] = 32'hFFFF_FFFF;
        bus.req_be[0 +: 4]     = 4'b0000;
        bus.req_valid = 2'b01;
        bus.rsp_ready = 2'b01;
        #1;
        check("be0_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 2'b00;
        #1;
        check("be0_mem_we", 32'(bus.mem_we), 32'h0);
        check("be0_mem_a", bus.mem_a, 32'h20);
        tick();
        check("be0_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("be0_rsp_rdata", bus.rsp_rdata, 32'h1000_0008);
        tick();
        check("be0_we_pulses", 32'(we_cnt - we_base), 32'h0);
        check("be0_ram8", ram[8], 32'h1000_0008);

        // Reset during ACCESS of a full-word store to RAM[3].
        bus.req_addr[0 +: 32]  = 32'h0000_000C;
        bus.req_wdata[0 +: 32] = 32'hCAFE_F00D;
        bus.req_be[0 +: 4]     = 4'b1111;
        bus.req_valid = 2'b01;
        #1;
        check("mr_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 2'b00;
        #1;
        check("mr_mem_we_pre", 32'(bus.mem_we), 32'h1);
        check("mr_mem_wd_pre", bus.mem_wd, 32'hCAFE_F00D);
        rst_n = 1'b0;
        #1;
        check("mr_mem_we", 32'(bus.mem_we), 32'h0);
        check("mr_mem_a", bus.mem_a, 32'h0);
        check("mr_mem_wd", bus.mem_wd, 32'h0);
        check("mr_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("mr_rsp_rdata", bus.rsp_rdata, 32'h0);
        tick();
        check("mr_ram3", ram[3], 32'h3333_3333);
        rst_n = 1'b1;
        bus.req_we    = 2'b00;
        bus.req_valid = 2'b11;
        #1;
        check("mr_prio0", 32'(bus.req_ready), 32'h1);
        check("no_dual_ready", 32'(dual_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
